// File: rtl/dvi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dvi_pkg
// Purpose  : Shared FSM states, control-token polarity and timing helpers.
// Revision : 1.0
// ============================================================================
package dvi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } dvi_state_e;

  localparam logic c_pol_active_high = 1'b1;

  function automatic int dvi_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dvi_raster_cnt.sv
`default_nettype none
// ============================================================================
// Module   : dvi_raster_cnt
// Purpose  : Horizontal/vertical raster counter with wrap and last-pixel flag.
// Revision : 1.0
// ============================================================================
module dvi_raster_cnt #(
  parameter int H_TOTAL = 1650,
  parameter int V_TOTAL = 750,
  localparam int HW = $clog2(H_TOTAL),
  localparam int VW = $clog2(V_TOTAL)
) (
  input  logic          sys_clk_i,
  input  logic          rst_i,
  input  logic          cnt_en_i,
  output logic [HW-1:0] h_o,
  output logic [VW-1:0] v_o,
  output logic          last_o
);

  localparam logic [HW-1:0] c_h_last = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] c_v_last = VW'(V_TOTAL - 1);

  logic [HW-1:0] r_h;
  logic [VW-1:0] r_v;
  logic          w_h_wrap;
  logic          w_v_wrap;

  assign w_h_wrap = (r_h == c_h_last);
  assign w_v_wrap = (r_v == c_v_last);
  assign last_o   = w_h_wrap && w_v_wrap;
  assign h_o      = r_h;
  assign v_o      = r_v;

  always_ff @(posedge sys_clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_h <= '0;
      r_v <= '0;
    end else if (cnt_en_i) begin
      if (w_h_wrap) begin
        r_h <= '0;
        r_v <= w_v_wrap ? '0 : r_v + 1'b1;
      end else begin
        r_h <= r_h + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/dvi_timing_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dvi_timing_ctrl
// Purpose  : Raster timing, pixel fetch and aligned TMDS encoder input drive.
// Revision : 1.0
// ============================================================================
module dvi_timing_ctrl
  import dvi_pkg::*;
#(
  parameter int   H_ACTIVE = 1280,
  parameter int   H_FP     = 110,
  parameter int   H_SYNC   = 40,
  parameter int   H_BP     = 220,
  parameter int   V_ACTIVE = 720,
  parameter int   V_FP     = 5,
  parameter int   V_SYNC   = 5,
  parameter int   V_BP     = 20,
  parameter logic HS_POL   = c_pol_active_high,
  parameter logic VS_POL   = c_pol_active_high,
  localparam int  XW       = $clog2(H_ACTIVE),
  localparam int  YW       = $clog2(V_ACTIVE)
) (
  input  logic          sys_clk_i,
  input  logic          rst_i,
  input  logic          en_i,
  output logic          pix_req_o,
  output logic [XW-1:0] pix_x_o,
  output logic [YW-1:0] pix_y_o,
  input  logic [23:0]   pix_data_i,
  output logic          enc_de_o,
  output logic          enc_c0_o,
  output logic          enc_c1_o,
  output logic [7:0]    enc_r_o,
  output logic [7:0]    enc_g_o,
  output logic [7:0]    enc_b_o,
  output logic          frame_start_o,
  output logic          busy_o
);

  localparam int H_TOTAL = dvi_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = dvi_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] c_h_active  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] c_h_sync_lo = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] c_h_sync_hi = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] c_v_active  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] c_v_sync_lo = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] c_v_sync_hi = VW'(V_ACTIVE + V_FP + V_SYNC);

  if (H_FP < 1 || H_SYNC < 1 || H_BP < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_timing
    $error("dvi_timing_ctrl: porch and sync widths must all be at least 1");
  end

  dvi_state_e    r_state;
  logic          r_busy;
  logic [HW-1:0] w_h;
  logic [VW-1:0] w_v;
  logic          w_last;
  logic          w_run;
  logic          w_active;
  logic          w_hsync_raw;
  logic          w_vsync_raw;
  logic          w_first;
  logic          r_active_d1;
  logic          r_hsync_d1;
  logic          r_vsync_d1;
  logic          r_first_d1;

  // Counters only advance outside IDLE, so they sit at (0,0) ready for the next start.
  dvi_raster_cnt #(
    .H_TOTAL (H_TOTAL),
    .V_TOTAL (V_TOTAL)
  ) u_raster_cnt (
    .sys_clk_i (sys_clk_i),
    .rst_i     (rst_i),
    .cnt_en_i  (w_run),
    .h_o       (w_h),
    .v_o       (w_v),
    .last_o    (w_last)
  );

  assign w_run       = (r_state != IDLE);
  assign w_active    = w_run && (w_h < c_h_active) && (w_v < c_v_active);
  assign w_hsync_raw = w_run && (w_h >= c_h_sync_lo) && (w_h < c_h_sync_hi);
  assign w_vsync_raw = w_run && (w_v >= c_v_sync_lo) && (w_v < c_v_sync_hi);
  assign w_first     = w_run && (w_h == '0) && (w_v == '0);

  assign pix_req_o = w_active;
  assign pix_x_o   = w_active ? w_h[XW-1:0] : '0;
  assign pix_y_o   = w_active ? w_v[YW-1:0] : '0;
  assign busy_o    = r_busy;

  // Stopping is only honoured on the last pixel so frames are never truncated.
  always_ff @(posedge sys_clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (en_i) begin
            r_state <= RUN;
            r_busy  <= 1'b1;
          end
        end
        RUN: begin
          if (!en_i) begin
            if (w_last) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (en_i) begin
            r_state <= RUN;
          end else if (w_last) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge sys_clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_active_d1 <= 1'b0;
      r_hsync_d1  <= 1'b0;
      r_vsync_d1  <= 1'b0;
      r_first_d1  <= 1'b0;
    end else begin
      r_active_d1 <= w_active;
      r_hsync_d1  <= w_hsync_raw;
      r_vsync_d1  <= w_vsync_raw;
      r_first_d1  <= w_first;
    end
  end

  // pix_data_i arrives alongside the stage-1 flags, so everything lands together here.
  always_ff @(posedge sys_clk_i or posedge rst_i) begin
    if (rst_i) begin
      enc_de_o      <= 1'b0;
      enc_c0_o      <= ~HS_POL;
      enc_c1_o      <= ~VS_POL;
      enc_r_o       <= '0;
      enc_g_o       <= '0;
      enc_b_o       <= '0;
      frame_start_o <= 1'b0;
    end else begin
      enc_de_o      <= r_active_d1;
      enc_c0_o      <= r_hsync_d1 ? HS_POL : ~HS_POL;
      enc_c1_o      <= r_vsync_d1 ? VS_POL : ~VS_POL;
      enc_r_o       <= r_active_d1 ? pix_data_i[23:16] : 8'd0;
      enc_g_o       <= r_active_d1 ? pix_data_i[15:8]  : 8'd0;
      enc_b_o       <= r_active_d1 ? pix_data_i[7:0]   : 8'd0;
      frame_start_o <= r_first_d1 && r_active_d1;
    end
  end

endmodule
`default_nettype wire
